// File: rtl/aesha_pkg.sv
// Shared types, geometry constants and helpers for the theta-parity datapath.
package aesha_pkg;

    localparam int unsigned LANE_W_DEF = 32;
    localparam int unsigned NCOLS      = 5;

    typedef logic [LANE_W_DEF-1:0] lane_t;
    typedef lane_t [0:NCOLS-1]     lane_row_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } theta_state_e;

    function automatic lane_t rotl(input lane_t lane, input int unsigned amount);
        lane_t   res;
        int unsigned amt;
        amt = amount % LANE_W_DEF;
        res = lane;
        for (int unsigned i = 0; i < amt; i++) begin
            res = {res[LANE_W_DEF-2:0], res[LANE_W_DEF-1]};
        end
        return res;
    endfunction

endpackage

// File: rtl/theta_shift.sv
// Combinational theta mix: C_shifted[x] = C[x-1] ^ rotl(C[x+1], ROT), indices mod 5.
module theta_shift
    import aesha_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned ROT    = 1
) (
    input  logic [0:NCOLS-1][LANE_W-1:0] c,
    output logic [0:NCOLS-1][LANE_W-1:0] c_shifted
);

    // Rotation by a constant amount is just a fixed slice of the doubled word.
    function automatic logic [LANE_W-1:0] rot_const(input logic [LANE_W-1:0] v);
        logic [2*LANE_W-1:0] d;
        d = {v, v};
        return d[2*LANE_W-1-ROT -: LANE_W];
    endfunction

    always_comb begin
        c_shifted = '0;
        for (int x = 0; x < NCOLS; x++) begin
            c_shifted[x] = c[(x + NCOLS - 1) % NCOLS] ^ rot_const(c[(x + 1) % NCOLS]);
        end
    end

endmodule

// File: rtl/theta_parity_acc.sv
// Accumulates five row beats into column parities and holds the registered
// theta-shifted result until the downstream stage accepts it.
module theta_parity_acc
    import aesha_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned NROWS  = NCOLS,
    parameter int unsigned ROT    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [0:NCOLS-1][LANE_W-1:0]  i_row,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [0:NCOLS-1][LANE_W-1:0]  o_C,
    output logic [0:NCOLS-1][LANE_W-1:0]  o_C_shifted,
    output logic                          o_busy
);

    localparam int unsigned CntW = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(NROWS - 1);

    theta_state_e                  state_q, state_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [0:NCOLS-1][LANE_W-1:0]  acc_q, acc_d;
    logic [0:NCOLS-1][LANE_W-1:0]  c_q, c_d;
    logic [0:NCOLS-1][LANE_W-1:0]  cs_q, cs_d;
    logic                          valid_q, valid_d;
    logic [0:NCOLS-1][LANE_W-1:0]  row_par;
    logic [0:NCOLS-1][LANE_W-1:0]  par_shift;
    logic                          accept;

    theta_shift #(
        .LANE_W (LANE_W),
        .ROT    (ROT)
    ) u_theta_shift (
        .c         (row_par),
        .c_shifted (par_shift)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cs_d    = cs_q;
        valid_d = valid_q;
        accept  = i_valid && (state_q == ACCUM);

        // Beat 0 loads rather than XORs, so no stale parity survives a turnaround.
        for (int x = 0; x < NCOLS; x++) begin
            row_par[x] = ((cnt_q == '0) ? '0 : acc_q[x]) ^ i_row[x];
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = row_par;
                    if (cnt_q == LastBeat) begin
                        state_d = OUT;
                        cnt_d   = '0;
                        c_d     = row_par;
                        cs_d    = par_shift;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (i_ready) begin
                    state_d = ACCUM;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            cs_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cs_q    <= cs_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready     = (state_q == ACCUM) && !i_rst;
    assign o_valid     = valid_q;
    assign o_C         = c_q;
    assign o_C_shifted = cs_q;
    assign o_busy      = (state_q == ACCUM) && (cnt_q != '0);

endmodule
